hilo_sched: RTL and testbench
=============================

# hilo_sched

Multi-cycle HI/LO scheduler for the five-stage MIPS pipeline. It accepts mult/div/mthi/mtlo operations issued from the E stage and runs the multiply or divide for a fixed latency. It owns the HI and LO registers and raises a stall request that holds a decode-stage HI/LO instruction until the unit is free. Its HI/LO outputs feed the HILO input of the E/M pipeline register.

## Interface
- MULT_CYCLES, 5: busy cycles for MULT/MULTU (≥1)
- DIV_CYCLES, 10: busy cycles for DIV/DIVU (≥1)
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  E-stage instruction is a valid HI/LO operation this cycle
- op  in  3  1=MULT, 2=MULTU, 3=DIV, 4=DIVU, 5=MTHI, 6=MTLO; 0/7 = no-op
- A  in  32  rs operand (dividend / multiplicand / MT source)
- B  in  32  rt operand (divisor / multiplier)
- D_use_hilo  in  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo
- busy  out  1  multi-cycle operation in progress
- stall  out  1  D-stage stall request, combinational
- HI  out  32  HI register
- LO  out  32  LO register

## Operation
- States: IDLE (count==0), RUN (count!=0). Internal: count (≥4 bits, sized for max parameter), pend_hi, pend_lo.
- IDLE, start=1, op∈{1..4}: on edge, compute result into pend_hi/pend_lo; count <= MULT_CYCLES or DIV_CYCLES; go RUN.
- MULT: signed 32x32→64; MULTU: unsigned; HI=upper 32, LO=lower 32.
- DIV: signed; LO=quotient truncated toward zero, HI=remainder with sign of dividend. DIVU: unsigned.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000.
- Divide by zero (B==0): full DIV_CYCLES busy; pend_hi/pend_lo = current HI/LO (HI/LO unchanged at completion).
- RUN: count decrements each edge; on edge where count goes 1→0, HI<=pend_hi, LO<=pend_lo; return to IDLE.
- MTHI/MTLO (op 5/6) in IDLE: HI (resp. LO) <= A on that edge; no busy period.
- start while RUN: ignored (no state change). Stall logic guarantees this does not occur legally.
- op 0/7 with start=1: ignored.
- busy = (count != 0).
- stall = D_use_hilo & (busy | (start & op∈{1..4})).
- mfhi/mflo read HI/LO outputs directly; new values are visible only after completion.

## Timing
- Reset (reset=0, asynchronous): count=0, HI=0, LO=0, pend_hi=0, pend_lo=0; busy=0. stall is combinational; it equals 0 unless D_use_hilo and a multi-cycle start are asserted during reset.
- Reset mid-RUN aborts the operation; no pending result is written.
- Start sampled at edge t: busy=1 from t through t+N-1 (exactly N cycles). HI/LO update at edge t+N, coincident with busy falling.
- MTHI/MTLO at edge t: HI/LO new value visible from t.
- stall asserts combinationally in the start cycle itself, so a D-stage mfhi behind a mult never passes.
- Back-to-back: start accepted in the cycle busy first reads 0. Minimum spacing between multi-cycle starts is N+1 cycles.

## Test plan
- Reset low with busy mid-count -> busy=0, HI=LO=0 immediately, without a clock edge; after release, no stale write occurs.
- MULT A=0xFFFFFFFE (-2), B=3 -> busy for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV A=-7 (0xFFFFFFF9), B=2 -> 10 busy cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 -> LO=3, HI=1. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIV by zero with HI=0x11, LO=0x22 preset via MTHI/MTLO -> 10 busy cycles, HI/LO still 0x11/0x22.
- Stall: D_use_hilo=1 throughout a MULT -> stall high from the start cycle for 6 cycles total, low the cycle after HI/LO update. Second start issued while busy -> ignored, and the first result is intact.
- MTLO A=0xDEADBEEF while idle -> LO=0xDEADBEEF next edge, busy stays 0. Same op with parameters MULT_CYCLES=1 -> MULT completes with busy high for a single cycle.

Source files
------------

// File: rtl/hilo_sched.sv
// HI/LO scheduler for the five-stage MIPS pipeline: owns HI/LO, runs mult/div for a fixed
// latency and requests a decode-stage stall while a HI/LO result is outstanding.
module hilo_sched #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        D_use_hilo,
    output logic        busy,
    output logic        stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntBits   = $clog2(MaxCycles + 1);
    localparam int unsigned CntW      = (CntBits > 4) ? CntBits : 4;

    localparam logic [CntW-1:0] MultCnt = CntW'(MULT_CYCLES);
    localparam logic [CntW-1:0] DivCnt  = CntW'(DIV_CYCLES);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    localparam logic [2:0] OpMult  = 3'd1;
    localparam logic [2:0] OpMultu = 3'd2;
    localparam logic [2:0] OpDiv   = 3'd3;
    localparam logic [2:0] OpDivu  = 3'd4;
    localparam logic [2:0] OpMthi  = 3'd5;
    localparam logic [2:0] OpMtlo  = 3'd6;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [31:0]       hi_q, hi_d;
    logic [31:0]       lo_q, lo_d;
    logic [31:0]       pend_hi_q, pend_hi_d;
    logic [31:0]       pend_lo_q, pend_lo_d;

    logic [63:0] mul_s;
    logic [63:0] mul_u;
    logic        div_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [63:0] udiv_res;
    logic [31:0] div_quo;
    logic [31:0] div_rem;
    logic        mc_op;

    // Restoring divider on magnitudes; returns {remainder, quotient}.
    function automatic logic [63:0] udiv32(input logic [31:0] n, input logic [31:0] d);
        logic [32:0] rem;
        logic [31:0] quo;
        rem = '0;
        quo = '0;
        for (int i = 31; i >= 0; i--) begin
            rem = {rem[31:0], n[i]};
            if (rem >= {1'b0, d}) begin
                rem    = rem - {1'b0, d};
                quo[i] = 1'b1;
            end
        end
        return {rem[31:0], quo};
    endfunction

    always_comb begin
        mul_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        mul_u = {32'd0, A} * {32'd0, B};

        div_signed = (op == OpDiv);
        a_neg      = div_signed & A[31];
        b_neg      = div_signed & B[31];
        a_mag      = a_neg ? (~A + 32'd1) : A;
        b_mag      = b_neg ? (~B + 32'd1) : B;
        udiv_res   = udiv32(a_mag, b_mag);
        // Quotient truncates toward zero; remainder follows the dividend's sign.
        div_quo    = (a_neg ^ b_neg) ? (~udiv_res[31:0] + 32'd1) : udiv_res[31:0];
        div_rem    = a_neg ? (~udiv_res[63:32] + 32'd1) : udiv_res[63:32];
    end

    assign mc_op = (op == OpMult) | (op == OpMultu) | (op == OpDiv) | (op == OpDivu);

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    case (op)
                        OpMult: begin
                            pend_hi_d = mul_s[63:32];
                            pend_lo_d = mul_s[31:0];
                            count_d   = MultCnt;
                            state_d   = StRun;
                        end
                        OpMultu: begin
                            pend_hi_d = mul_u[63:32];
                            pend_lo_d = mul_u[31:0];
                            count_d   = MultCnt;
                            state_d   = StRun;
                        end
                        OpDiv, OpDivu: begin
                            // Divide by zero still occupies the unit but leaves HI/LO as is.
                            if (B == 32'd0) begin
                                pend_hi_d = hi_q;
                                pend_lo_d = lo_q;
                            end else begin
                                pend_hi_d = div_rem;
                                pend_lo_d = div_quo;
                            end
                            count_d = DivCnt;
                            state_d = StRun;
                        end
                        OpMthi:  hi_d = A;
                        OpMtlo:  lo_d = A;
                        default: ;
                    endcase
                end
            end
            StRun: begin
                count_d = count_q - CntOne;
                if (count_q == CntOne) begin
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            count_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
        end
    end

    assign busy  = (count_q != '0);
    // Stalls in the start cycle too, so a following mfhi/mflo never sees stale HI/LO.
    assign stall = D_use_hilo & (busy | (start & mc_op));
    assign HI    = hi_q;
    assign LO    = lo_q;

endmodule

// File: tb/tb_hilo_sched.sv
// Bench for hilo_sched: two instances (MULT_CYCLES 5 and 1) share directed stimulus and are
// compared every cycle against a time-based behavioural model, plus literal spot checks.
module tb_hilo_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        D_use_hilo = 1'b0;

    logic        busy0, stall0, busy1, stall1;
    logic [31:0] hi0, lo0, hi1, lo1;

    int errors = 0;
    int checks = 0;
    bit check_en = 1'b0;

    localparam int DivN = 10;
    int mult_n[2] = '{5, 1};

    // Model state: pending result lands on edge number m_done.
    logic [31:0] m_hi[2]  = '{32'd0, 32'd0};
    logic [31:0] m_lo[2]  = '{32'd0, 32'd0};
    logic [31:0] m_phi[2] = '{32'd0, 32'd0};
    logic [31:0] m_plo[2] = '{32'd0, 32'd0};
    bit          m_pend[2] = '{1'b0, 1'b0};
    longint      m_done[2] = '{0, 0};
    longint      edge_no = 0;

    always #5 clk = ~clk;

    hilo_sched #(.MULT_CYCLES(5), .DIV_CYCLES(DivN)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
        .D_use_hilo(D_use_hilo), .busy(busy0), .stall(stall0), .HI(hi0), .LO(lo0)
    );

    hilo_sched #(.MULT_CYCLES(1), .DIV_CYCLES(DivN)) dut1 (
        .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
        .D_use_hilo(D_use_hilo), .busy(busy1), .stall(stall1), .HI(hi1), .LO(lo1)
    );

    function automatic logic [63:0] model_result(input logic [2:0] o, input logic [31:0] a,
                                                 input logic [31:0] b, input logic [31:0] hi,
                                                 input logic [31:0] lo);
        longint x, y, q, r;
        logic [31:0] uq, ur;
        logic [63:0] res;
        res = {hi, lo};
        x = longint'($signed(a));
        y = longint'($signed(b));
        case (o)
            3'd1: begin
                q   = x * y;
                res = q;
            end
            3'd2: res = {32'd0, a} * {32'd0, b};
            3'd3: if (b != 32'd0) begin
                q   = x / y;
                r   = x % y;
                res = {r[31:0], q[31:0]};
            end
            3'd4: if (b != 32'd0) begin
                uq  = a / b;
                ur  = a % b;
                res = {ur, uq};
            end
            default: ;
        endcase
        return res;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                m_hi[k] = '0; m_lo[k] = '0; m_phi[k] = '0; m_plo[k] = '0; m_pend[k] = 1'b0;
            end
        end else begin
            edge_no++;
            for (int k = 0; k < 2; k++) begin
                if (m_pend[k]) begin
                    if (edge_no == m_done[k]) begin
                        m_hi[k]   = m_phi[k];
                        m_lo[k]   = m_plo[k];
                        m_pend[k] = 1'b0;
                    end
                end else if (start) begin
                    if (op >= 3'd1 && op <= 3'd4) begin
                        {m_phi[k], m_plo[k]} = model_result(op, A, B, m_hi[k], m_lo[k]);
                        m_pend[k] = 1'b1;
                        m_done[k] = edge_no + ((op <= 3'd2) ? mult_n[k] : DivN);
                    end else if (op == 3'd5) begin
                        m_hi[k] = A;
                    end else if (op == 3'd6) begin
                        m_lo[k] = A;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_inst(input int k, input logic b, input logic s, input logic [31:0] h,
                            input logic [31:0] l);
        logic exp_stall;
        exp_stall = D_use_hilo & (m_pend[k] | (start & (op >= 3'd1) & (op <= 3'd4)));
        chk($sformatf("u%0d_busy", k), {31'd0, b}, {31'd0, m_pend[k]});
        chk($sformatf("u%0d_stall", k), {31'd0, s}, {31'd0, exp_stall});
        chk($sformatf("u%0d_hi", k), h, m_hi[k]);
        chk($sformatf("u%0d_lo", k), l, m_lo[k]);
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            cmp_inst(0, busy0, stall0, hi0, lo0);
            cmp_inst(1, busy1, stall1, hi1, lo1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; A = a; B = b;
        tick();
        start = 1'b0; op = 3'd0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy0 && n < 40) begin
            n++;
            tick();
        end
        if (busy0) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: busy still %b after %0d cycles", busy0, n);
        end
    endtask

    initial begin
        int n;
        check_en = 1'b1;
        #1;
        chk("rst_busy", {31'd0, busy0}, 32'd0);
        chk("rst_hi", hi0, 32'd0);
        tick();
        reset = 1'b1;
        tick();

        issue(3'd1, 32'hFFFF_FFFE, 32'd3);
        wait_idle(n);
        chk("mult_cycles", n, 32'd5);
        chk("mult_hi", hi0, 32'hFFFF_FFFF);
        chk("mult_lo", lo0, 32'hFFFF_FFFA);

        issue(3'd2, 32'hFFFF_FFFE, 32'd3);
        wait_idle(n);
        chk("multu_hi", hi0, 32'h0000_0002);
        chk("multu_lo", lo0, 32'hFFFF_FFFA);

        issue(3'd3, 32'hFFFF_FFF9, 32'd2);
        wait_idle(n);
        chk("div_cycles", n, 32'd10);
        chk("div_lo", lo0, 32'hFFFF_FFFD);
        chk("div_hi", hi0, 32'hFFFF_FFFF);

        issue(3'd4, 32'd7, 32'd2);
        wait_idle(n);
        chk("divu_lo", lo0, 32'd3);
        chk("divu_hi", hi0, 32'd1);

        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(n);
        chk("divovf_lo", lo0, 32'h8000_0000);
        chk("divovf_hi", hi0, 32'd0);

        issue(3'd5, 32'h11, 32'd0);
        chk("mthi_busy", {31'd0, busy0}, 32'd0);
        chk("mthi_hi", hi0, 32'h11);
        issue(3'd6, 32'h22, 32'd0);
        issue(3'd3, 32'd5, 32'd0);
        wait_idle(n);
        chk("div0_cycles", n, 32'd10);
        chk("div0_hi", hi0, 32'h11);
        chk("div0_lo", lo0, 32'h22);

        issue(3'd6, 32'hDEAD_BEEF, 32'd0);
        chk("mtlo_busy", {31'd0, busy0}, 32'd0);
        chk("mtlo_lo", lo0, 32'hDEAD_BEEF);

        issue(3'd1, 32'd6, 32'd7);
        chk("m1_busy", {31'd0, busy1}, 32'd1);
        tick();
        chk("m1_idle", {31'd0, busy1}, 32'd0);
        chk("m1_lo", lo1, 32'd42);
        wait_idle(n);

        // Stall window: start cycle plus the five busy cycles.
        D_use_hilo = 1'b1;
        start = 1'b1; op = 3'd1; A = 32'd3; B = 32'd4;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (stall0) n++;
            @(posedge clk);
            #1;
            start = 1'b0; op = 3'd0;
        end
        D_use_hilo = 1'b0;
        chk("stall_cycles", n, 32'd6);
        chk("stall_lo", lo0, 32'd12);

        issue(3'd1, 32'd2, 32'd3);
        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(3'd5, 32'h99, 32'd0);
        wait_idle(n);
        chk("ign_hi", hi0, 32'd0);
        chk("ign_lo", lo0, 32'd6);

        issue(3'd5, 32'h55, 32'd0);
        issue(3'd4, 32'd100, 32'd7);
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy0}, 32'd0);
        chk("arst_hi", hi0, 32'd0);
        chk("arst_lo", lo0, 32'd0);
        tick();
        reset = 1'b1;
        repeat (15) tick();
        chk("post_rst_hi", hi0, 32'd0);
        chk("post_rst_lo", lo0, 32'd0);
        chk("post_rst_busy", {31'd0, busy0}, 32'd0);

        issue(3'd4, 32'd100, 32'd7);
        wait_idle(n);
        chk("divu2_lo", lo0, 32'd14);
        chk("divu2_hi", hi0, 32'd2);

        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
